// File: rtl/control_seq.sv
// control_seq: fetch/decode/execute sequencer for the 8-bit processor.
// State-only strobes are registered from the next-state decode; handshake strobes are Mealy on mem_ready.
module control_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic       mem_ready,
    input  logic       zero_flag,
    input  logic       carry_flag,
    output logic       pc_on_bus,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       mar_ld,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       data_on_ir,
    output logic       ir_op_on_bus,
    output logic       acc_ld,
    output logic       acc_on_bus,
    output logic       alu_ld,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic [3:0] state_o
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_STA = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB = 4'h4;
    localparam logic [OP_W-1:0] OP_AND = 4'h5;
    localparam logic [OP_W-1:0] OP_OR  = 4'h6;
    localparam logic [OP_W-1:0] OP_XOR = 4'h7;
    localparam logic [OP_W-1:0] OP_LDI = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP = 4'h9;
    localparam logic [OP_W-1:0] OP_JZ  = 4'hA;
    localparam logic [OP_W-1:0] OP_JC  = 4'hB;
    localparam logic [OP_W-1:0] OP_NOT = 4'hC;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    localparam logic [ALU_W-1:0] ALU_NOT = 3'b101;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH_A = 4'd1,
        S_FETCH_M = 4'd2,
        S_DECODE  = 4'd3,
        S_MEM_A   = 4'd4,
        S_MEM_R   = 4'd5,
        S_MEM_W   = 4'd6,
        S_EXEC_I  = 4'd7,
        S_EXEC_J  = 4'd8,
        S_EXEC_N  = 4'd9,
        S_HALT    = 4'd10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_is_sta;
    logic             w_is_sta_nxt;
    logic [OP_W-1:0]  w_opcode;
    logic             w_unused_operand;

    logic r_pc_on_bus, r_pc_ld, r_mar_ld, r_mem_rd, r_mem_wr, r_ir_op_on_bus;
    logic r_acc_ld, r_acc_on_bus, r_alu_ld, r_halted;
    logic [ALU_W-1:0] r_alu_op;
    logic w_pc_on_bus, w_pc_ld, w_mar_ld, w_mem_rd, w_mem_wr, w_ir_op_on_bus;
    logic w_acc_ld, w_acc_on_bus, w_alu_ld, w_halted;
    logic [ALU_W-1:0] w_alu_op;

    logic w_fm_done, w_mr_done, w_mr_lda, w_mr_alu;

    assign w_opcode = ir[7:4];
    // The operand is consumed by the datapath; only the opcode steers sequencing.
    assign w_unused_operand = ^ir[3:0];

    // Next-state logic; STA-vs-read is latched in DECODE so MEM_A ignores ir.
    always_comb begin
        w_state_nxt  = S_RST;
        w_is_sta_nxt = r_is_sta;
        case (r_state)
            S_RST:     w_state_nxt = S_FETCH_A;
            S_FETCH_A: w_state_nxt = S_FETCH_M;
            S_FETCH_M: w_state_nxt = mem_ready ? S_DECODE : S_FETCH_M;
            S_DECODE: begin
                w_is_sta_nxt = (w_opcode == OP_STA);
                case (w_opcode)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB,
                    OP_AND, OP_OR, OP_XOR: w_state_nxt = S_MEM_A;
                    OP_LDI:                w_state_nxt = S_EXEC_I;
                    OP_JMP:                w_state_nxt = S_EXEC_J;
                    OP_JZ:                 w_state_nxt = zero_flag  ? S_EXEC_J : S_FETCH_A;
                    OP_JC:                 w_state_nxt = carry_flag ? S_EXEC_J : S_FETCH_A;
                    OP_NOT:                w_state_nxt = S_EXEC_N;
                    OP_HLT:                w_state_nxt = S_HALT;
                    default:               w_state_nxt = S_FETCH_A;
                endcase
            end
            S_MEM_A:   w_state_nxt = r_is_sta ? S_MEM_W : S_MEM_R;
            S_MEM_R:   w_state_nxt = mem_ready ? S_FETCH_A : S_MEM_R;
            S_MEM_W:   w_state_nxt = mem_ready ? S_FETCH_A : S_MEM_W;
            S_EXEC_I:  w_state_nxt = S_FETCH_A;
            S_EXEC_J:  w_state_nxt = S_FETCH_A;
            S_EXEC_N:  w_state_nxt = S_FETCH_A;
            S_HALT:    w_state_nxt = S_HALT;
            default:   w_state_nxt = S_RST;
        endcase
    end

    // State-only strobes for the state being entered.
    always_comb begin
        w_pc_on_bus    = 1'b0;
        w_pc_ld        = 1'b0;
        w_mar_ld       = 1'b0;
        w_mem_rd       = 1'b0;
        w_mem_wr       = 1'b0;
        w_ir_op_on_bus = 1'b0;
        w_acc_ld       = 1'b0;
        w_acc_on_bus   = 1'b0;
        w_alu_ld       = 1'b0;
        w_alu_op       = '0;
        w_halted       = 1'b0;
        case (w_state_nxt)
            S_FETCH_A: begin w_pc_on_bus = 1'b1; w_mar_ld = 1'b1; end
            S_FETCH_M: w_mem_rd = 1'b1;
            S_MEM_A:   begin w_ir_op_on_bus = 1'b1; w_mar_ld = 1'b1; end
            S_MEM_R:   w_mem_rd = 1'b1;
            S_MEM_W:   begin w_acc_on_bus = 1'b1; w_mem_wr = 1'b1; end
            S_EXEC_I:  begin w_ir_op_on_bus = 1'b1; w_acc_ld = 1'b1; end
            S_EXEC_J:  begin w_ir_op_on_bus = 1'b1; w_pc_ld = 1'b1; end
            S_EXEC_N:  begin w_alu_ld = 1'b1; w_alu_op = ALU_NOT; end
            S_HALT:    w_halted = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_RST;
            r_is_sta       <= 1'b0;
            r_pc_on_bus    <= 1'b0;
            r_pc_ld        <= 1'b0;
            r_mar_ld       <= 1'b0;
            r_mem_rd       <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_ir_op_on_bus <= 1'b0;
            r_acc_ld       <= 1'b0;
            r_acc_on_bus   <= 1'b0;
            r_alu_ld       <= 1'b0;
            r_alu_op       <= '0;
            r_halted       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_is_sta       <= w_is_sta_nxt;
            r_pc_on_bus    <= w_pc_on_bus;
            r_pc_ld        <= w_pc_ld;
            r_mar_ld       <= w_mar_ld;
            r_mem_rd       <= w_mem_rd;
            r_mem_wr       <= w_mem_wr;
            r_ir_op_on_bus <= w_ir_op_on_bus;
            r_acc_ld       <= w_acc_ld;
            r_acc_on_bus   <= w_acc_on_bus;
            r_alu_ld       <= w_alu_ld;
            r_alu_op       <= w_alu_op;
            r_halted       <= w_halted;
        end
    end

    // Handshake strobes fire only in the cycle memory completes.
    assign w_fm_done = (r_state == S_FETCH_M) && mem_ready;
    assign w_mr_done = (r_state == S_MEM_R) && mem_ready;
    assign w_mr_lda  = w_mr_done && (w_opcode == OP_LDA);
    assign w_mr_alu  = w_mr_done && (w_opcode >= OP_ADD) && (w_opcode <= OP_XOR);

    assign pc_on_bus    = r_pc_on_bus;
    assign pc_inc       = w_fm_done;
    assign pc_ld        = r_pc_ld;
    assign mar_ld       = r_mar_ld;
    assign mem_rd       = r_mem_rd;
    assign mem_wr       = r_mem_wr;
    assign data_on_ir   = w_fm_done;
    assign ir_op_on_bus = r_ir_op_on_bus;
    assign acc_ld       = r_acc_ld | w_mr_lda;
    assign acc_on_bus   = r_acc_on_bus;
    assign alu_ld       = r_alu_ld | w_mr_alu;
    assign alu_op       = w_mr_alu ? ALU_W'(w_opcode - OP_ADD) : r_alu_op;
    assign halted       = r_halted;
    assign state_o      = 4'(r_state);

endmodule

// File: tb/tb_control_seq.sv
// Testbench for control_seq: per-instruction cycle traces built from the instruction timing rules.
module tb_control_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ir = 8'h00;
    logic       mem_ready = 1'b0;
    logic       zero_flag = 1'b0;
    logic       carry_flag = 1'b0;
    logic       pc_on_bus, pc_inc, pc_ld, mar_ld, mem_rd, mem_wr, data_on_ir;
    logic       ir_op_on_bus, acc_ld, acc_on_bus, alu_ld, halted;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    control_seq dut (
        .clk(clk), .rst(rst), .ir(ir), .mem_ready(mem_ready),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .pc_on_bus(pc_on_bus), .pc_inc(pc_inc), .pc_ld(pc_ld), .mar_ld(mar_ld),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .data_on_ir(data_on_ir),
        .ir_op_on_bus(ir_op_on_bus), .acc_ld(acc_ld), .acc_on_bus(acc_on_bus),
        .alu_ld(alu_ld), .alu_op(alu_op), .halted(halted), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] S_RST = 4'd0, S_FA = 4'd1, S_FM = 4'd2, S_DEC = 4'd3;
    localparam logic [3:0] S_MA = 4'd4, S_MR = 4'd5, S_MW = 4'd6, S_EI = 4'd7;
    localparam logic [3:0] S_EJ = 4'd8, S_EN = 4'd9, S_HLT = 4'd10;

    localparam logic [15:0] O_PCB = 16'h8000, O_PCI = 16'h4000, O_PCL = 16'h2000;
    localparam logic [15:0] O_MAR = 16'h1000, O_RD = 16'h0800, O_WR = 16'h0400;
    localparam logic [15:0] O_DIR = 16'h0200, O_IROP = 16'h0100, O_ACCL = 16'h0080;
    localparam logic [15:0] O_ACCB = 16'h0040, O_ALU = 16'h0020, O_HALT = 16'h0002;

    wire [15:0] w_outs = {pc_on_bus, pc_inc, pc_ld, mar_ld, mem_rd, mem_wr, data_on_ir,
                          ir_op_on_bus, acc_ld, acc_on_bus, alu_ld, alu_op, halted, 1'b0};

    function automatic logic [15:0] aluop(input logic [2:0] op);
        return {11'd0, op, 2'b00};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic check(input string tag, input logic [3:0] est, input logic [15:0] eo);
        checks++;
        assert ({state_o, w_outs} === {est, eo})
        else begin
            errors++;
            $error("FAIL %s: state/outs got %0d/%h want %0d/%h", tag, state_o, w_outs, est, eo);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check mid-cycle.
    task automatic step(input string tag, input logic [3:0] est, input logic [15:0] eo,
                        input logic rdy, input logic [7:0] irv, input logic zf, input logic cf);
        mem_ready  = rdy;
        ir         = irv;
        zero_flag  = zf;
        carry_flag = cf;
        @(negedge clk);
        check(tag, est, eo);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        #1;
        check("async_reset", S_RST, 16'h0);
        for (int i = 0; i < n; i++)
            step("reset_hold", S_RST, 16'h0, rb(), 8'($urandom), rb(), rb());
        rst = 1'b1;
        step("reset_release", S_RST, 16'h0, rb(), 8'($urandom), rb(), rb());
    endtask

    // Expected trace of one instruction from its class, flags and memory wait counts.
    task automatic run_instr(input logic [7:0] ins, input logic zf, input logic cf,
                             input int wf, input int wm, input int nhalt);
        int op;
        op = int'(ins[7:4]);
        step("fetch_a", S_FA, O_PCB | O_MAR, rb(), 8'($urandom), rb(), rb());
        for (int i = 0; i < wf; i++)
            step("fetch_wait", S_FM, O_RD, 1'b0, 8'($urandom), rb(), rb());
        step("fetch_done", S_FM, O_RD | O_DIR | O_PCI, 1'b1, 8'($urandom), rb(), rb());
        step("decode", S_DEC, 16'h0, rb(), ins, zf, cf);
        case (op)
            8:  step("exec_ldi", S_EI, O_IROP | O_ACCL, rb(), ins, rb(), rb());
            9:  step("exec_jmp", S_EJ, O_IROP | O_PCL, rb(), ins, rb(), rb());
            10: if (zf) step("exec_jz", S_EJ, O_IROP | O_PCL, rb(), ins, rb(), rb());
            11: if (cf) step("exec_jc", S_EJ, O_IROP | O_PCL, rb(), ins, rb(), rb());
            12: step("exec_not", S_EN, O_ALU | aluop(3'b101), rb(), ins, rb(), rb());
            15: for (int i = 0; i < nhalt; i++)
                    step("halt", S_HLT, O_HALT, rb(), 8'($urandom), rb(), rb());
            1, 2, 3, 4, 5, 6, 7: begin
                step("mem_a", S_MA, O_IROP | O_MAR, rb(), ins, rb(), rb());
                if (op == 2) begin
                    for (int i = 0; i < wm; i++)
                        step("mem_w_wait", S_MW, O_ACCB | O_WR, 1'b0, ins, rb(), rb());
                    step("mem_w_done", S_MW, O_ACCB | O_WR, 1'b1, ins, rb(), rb());
                end else begin
                    for (int i = 0; i < wm; i++)
                        step("mem_r_wait", S_MR, O_RD, 1'b0, ins, rb(), rb());
                    if (op == 1)
                        step("mem_r_lda", S_MR, O_RD | O_ACCL, 1'b1, ins, rb(), rb());
                    else
                        step("mem_r_alu", S_MR, O_RD | O_ALU | aluop(3'(op - 3)), 1'b1, ins, rb(), rb());
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        #2;
        do_reset(3);

        // Directed: fetch waits, ALU, store, conditional jumps, single-step ops.
        run_instr(8'h00, 1'b0, 1'b0, 2, 0, 0);
        run_instr(8'h35, 1'b0, 1'b0, 0, 0, 0);
        run_instr(8'h2A, 1'b0, 1'b0, 0, 1, 0);
        run_instr(8'h1C, 1'b1, 1'b1, 1, 2, 0);
        run_instr(8'h4E, 1'b0, 1'b0, 0, 0, 0);
        run_instr(8'h72, 1'b0, 1'b0, 0, 1, 0);
        run_instr(8'hA7, 1'b1, 1'b0, 0, 0, 0);
        run_instr(8'hA7, 1'b0, 1'b1, 0, 0, 0);
        run_instr(8'hB3, 1'b0, 1'b1, 0, 0, 0);
        run_instr(8'hB3, 1'b1, 1'b0, 0, 0, 0);
        run_instr(8'h85, 1'b0, 1'b0, 0, 0, 0);
        run_instr(8'h9F, 1'b0, 1'b0, 0, 0, 0);
        run_instr(8'hC0, 1'b0, 1'b0, 0, 0, 0);
        run_instr(8'hD1, 1'b1, 1'b1, 0, 0, 0);
        run_instr(8'hE2, 1'b1, 1'b1, 0, 0, 0);

        // Randomized instruction stream (HLT handled separately).
        for (int n = 0; n < 80; n++) begin
            logic [7:0] ins;
            ins = {4'($urandom_range(0, 14)), 4'($urandom)};
            run_instr(ins, rb(), rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
        end

        // Reset during a MEM_R wait: Mealy acc_ld is live, then reset kills everything at once.
        step("lda_fetch_a", S_FA, O_PCB | O_MAR, rb(), 8'($urandom), rb(), rb());
        step("lda_fetch_m", S_FM, O_RD | O_DIR | O_PCI, 1'b1, 8'($urandom), rb(), rb());
        step("lda_decode", S_DEC, 16'h0, rb(), 8'h13, rb(), rb());
        step("lda_mem_a", S_MA, O_IROP | O_MAR, rb(), 8'h13, rb(), rb());
        step("lda_mem_r_wait", S_MR, O_RD, 1'b0, 8'h13, rb(), rb());
        mem_ready = 1'b1;
        #1;
        check("lda_mealy_before_reset", S_MR, O_RD | O_ACCL);
        do_reset(1);

        run_instr(8'h61, 1'b0, 1'b0, 1, 0, 0);
        run_instr(8'hF0, 1'b0, 1'b0, 0, 0, 20);
        do_reset(2);
        run_instr(8'h00, 1'b0, 1'b0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
